// File: rtl/cmd_queue_pkg.sv
// Shared command-path types and sizing for the processor complex.
// Defines the command word carried between host loader, command queue and issuer.
package cmd_queue_pkg;

    localparam int PROC_COUNT      = 4;
    localparam int BUS_W           = 16;
    localparam int CMD_QUEUE_DEPTH = 16;
    localparam int CMD_QUEUE_AFULL = CMD_QUEUE_DEPTH - 4;
    localparam int PROC_ID_W       = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_STORE = 3'd2,
        CMD_EXEC  = 3'd3,
        CMD_SYNC  = 3'd4,
        CMD_HALT  = 3'd5
    } cmd_op_e;

    typedef struct packed {
        cmd_op_e              op;
        logic [PROC_ID_W-1:0] proc;
        logic [BUS_W-1:0]     arg;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cmd_fifo_mem.sv
// Command storage: DEPTH x CMD_W register array with two write ports and one
// combinational read port. Contents are deliberately not reset.
module cmd_fifo_mem
    import cmd_queue_pkg::*;
#(
    parameter int DEPTH = CMD_QUEUE_DEPTH,
    parameter int W     = CMD_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we0,
    input  logic [AW-1:0] i_waddr0,
    input  logic [W-1:0]  i_wdata0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_waddr1,
    input  logic [W-1:0]  i_wdata1,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // The controller never issues both ports to the same address in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_we0) begin
            mem_q[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            mem_q[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/cmd_queue.sv
// First-word-fall-through command queue feeding the issuer. Accepts host and
// requeue pushes; the last slot is held back so a requeue is never refused.
module cmd_queue
    import cmd_queue_pkg::*;
#(
    parameter int DEPTH     = CMD_QUEUE_DEPTH,
    parameter int AFULL_LVL = DEPTH - 4,
    parameter int CMD_W     = $bits(cmd_t),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_host_push,
    input  logic [CMD_W-1:0] i_host_cmd,
    output logic             o_host_rdy,
    input  logic             i_rq_push,
    input  logic [CMD_W-1:0] i_rq_cmd,
    input  logic             i_rd,
    output logic [CMD_W-1:0] o_cmd,
    output logic             o_empty,
    output logic             o_afull,
    output logic [CNT_W-1:0] o_count,
    input  logic             i_clr_err,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HOST_LIM  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             pop_ok;
    logic             rq_ok;
    logic             host_ok;
    logic             host_rdy;
    logic [PTR_W-1:0] host_waddr;
    logic [CMD_W-1:0] head_raw;

    // All acceptance decisions look at the registered count, before this cycle's pop.
    assign host_rdy = (count_q < HOST_LIM);
    assign pop_ok   = i_rd && (count_q != '0);
    assign rq_ok    = i_rq_push && ((count_q < FULL_CNT) || pop_ok);
    assign host_ok  = i_host_push && host_rdy;

    // Requeue takes the tail slot first; a same-cycle host entry lands behind it.
    assign host_waddr = rq_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(rq_ok) + PTR_W'(host_ok);
        count_d  = count_q + CNT_W'(rq_ok) + CNT_W'(host_ok) - CNT_W'(pop_ok);

        ovf_d = ovf_q;
        unf_d = unf_q;
        if ((i_host_push && !host_rdy) || (i_rq_push && !rq_ok)) begin
            ovf_d = 1'b1;
        end
        if (i_rd && (count_q == '0)) begin
            unf_d = 1'b1;
        end
        if (i_clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    cmd_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_mem (
        .i_clk    (i_clk),
        .i_we0    (rq_ok),
        .i_waddr0 (wr_ptr_q),
        .i_wdata0 (i_rq_cmd),
        .i_we1    (host_ok),
        .i_waddr1 (host_waddr),
        .i_wdata1 (i_host_cmd),
        .i_raddr  (rd_ptr_q),
        .o_rdata  (head_raw)
    );

    // Storage is never reset, so the head is masked while empty to keep o_cmd defined.
    assign o_cmd       = (count_q == '0) ? '0 : head_raw;
    assign o_empty     = (count_q == '0);
    assign o_host_rdy  = host_rdy;
    assign o_afull     = (count_q >= AFULL_CNT);
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule
